// File: rtl/core_boot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : core_boot_sequencer
//  Purpose  : Brings up the RV32I two-stage core. Holds the core in reset,
//             loads a little-endian program image from a byte stream into
//             instruction memory starting at word 0, then releases the core.
//  Ports    : clk, resetb       - clock, synchronous active-low reset
//             boot_en           - 1 = load an image after reset, 0 = run at once
//             boot_req          - pulse in RUN to reload (core re-held in reset)
//             byte_valid/data   - input byte stream
//             byte_ready        - byte accepted on valid && ready
//             imem_we/addr/wdata- instruction memory write port
//             core_resetb       - registered active-low reset to the core
//             busy, done, err   - status (loading / running / failed)
//  Options  : `define BOOT_CHECKSUM_EN adds a trailing 32-bit checksum word
//             that must equal the mod-2^32 sum of all image words.
//  Revision : 1.0 - initial release
// ============================================================================
module core_boot_sequencer #(
    parameter int IMEM_WORDS  = 1024,
    parameter int ADDR_W      = 10,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              boot_en,
    input  logic              boot_req,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_resetb,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_RUN   = 3'd5,
        ST_ERROR = 3'd6
`ifdef BOOT_CHECKSUM_EN
        ,
        ST_CSUM  = 3'd7
`endif
    } state_t;

    localparam logic [ADDR_W:0] c_IDX_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [7:0]      c_HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [31:0]     c_MAX_WORDS = 32'(IMEM_WORDS);

    state_t              r_state;
    state_t              w_next_state;

    logic [1:0]          r_byte_cnt;
    logic [23:0]         r_shift;       // previously accepted bytes of the group
    logic [ADDR_W:0]     r_len;         // one extra bit: N may equal IMEM_WORDS
    logic [ADDR_W:0]     r_word_idx;
    logic [7:0]          r_hold_cnt;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [31:0]         r_imem_wdata;
    logic                r_byte_ready;
    logic                r_imem_we;
    logic                r_core_resetb;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]         r_sum;
`endif

    logic                w_accept;
    logic                w_last_byte;
    logic [31:0]         w_word;
    logic                w_len_bad;
    logic [ADDR_W:0]     w_idx_inc;
    logic                w_last_word;
    logic                w_hold_last;
    logic                w_byte_ready;
    logic                w_imem_we;
    logic                w_core_resetb;
    logic                w_busy;
    logic                w_done;
    logic                w_err;

    // The newest byte lands in the top lane, so after four bytes the first
    // byte of the group has shifted down to bits [7:0] (little-endian).
    assign w_accept    = byte_valid & r_byte_ready;
    assign w_last_byte = w_accept & (r_byte_cnt == 2'd3);
    assign w_word      = {byte_data, r_shift};
    assign w_len_bad   = (w_word == 32'd0) || (w_word > c_MAX_WORDS);
    assign w_idx_inc   = r_word_idx + c_IDX_ONE;
    assign w_last_word = (w_idx_inc == r_len);
    assign w_hold_last = (r_hold_cnt == c_HOLD_LAST);

    // Next state plus the status outputs for that state; the outputs are
    // registered below so they change on the edge that enters the state.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_START: w_next_state = boot_en ? ST_LEN : ST_HOLD;
            ST_LEN: begin
                if (w_last_byte) w_next_state = w_len_bad ? ST_ERROR : ST_DATA;
            end
            ST_DATA: begin
                if (w_last_byte) w_next_state = ST_WRITE;
            end
            ST_WRITE: begin
                if (w_last_word) begin
`ifdef BOOT_CHECKSUM_EN
                    w_next_state = ST_CSUM;
`else
                    w_next_state = ST_HOLD;
`endif
                end else begin
                    w_next_state = ST_DATA;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM: begin
                if (w_last_byte) w_next_state = (w_word == r_sum) ? ST_HOLD : ST_ERROR;
            end
`endif
            ST_HOLD: begin
                if (w_hold_last) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (boot_req) w_next_state = ST_LEN;
            end
            ST_ERROR: w_next_state = ST_ERROR;
            default:  w_next_state = ST_START;
        endcase

        w_byte_ready  = 1'b0;
        w_imem_we     = 1'b0;
        w_core_resetb = 1'b0;
        w_busy        = 1'b0;
        w_done        = 1'b0;
        w_err         = 1'b0;
        unique case (w_next_state)
            ST_LEN, ST_DATA: begin
                w_byte_ready = 1'b1;
                w_busy       = 1'b1;
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM: begin
                w_byte_ready = 1'b1;
                w_busy       = 1'b1;
            end
`endif
            ST_WRITE: begin
                w_imem_we = 1'b1;
                w_busy    = 1'b1;
            end
            ST_HOLD:  w_busy = 1'b1;
            ST_RUN: begin
                w_core_resetb = 1'b1;
                w_done        = 1'b1;
            end
            ST_ERROR: w_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state       <= ST_START;
            r_byte_cnt    <= 2'd0;
            r_shift       <= 24'd0;
            r_len         <= '0;
            r_word_idx    <= '0;
            r_hold_cnt    <= 8'd0;
            r_imem_addr   <= '0;
            r_imem_wdata  <= 32'd0;
            r_byte_ready  <= 1'b0;
            r_imem_we     <= 1'b0;
            r_core_resetb <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_sum         <= 32'd0;
`endif
        end else begin
            r_state       <= w_next_state;
            r_byte_ready  <= w_byte_ready;
            r_imem_we     <= w_imem_we;
            r_core_resetb <= w_core_resetb;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_err         <= w_err;

            // Groups are only ever left after their fourth byte (or by reset),
            // so the 2-bit counter is naturally back at zero at each group start.
            if (w_accept) begin
                r_shift    <= w_word[31:8];
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end

            if (r_state == ST_LEN && w_last_byte && !w_len_bad) begin
                r_len      <= w_word[ADDR_W:0];
                r_word_idx <= '0;
            end

            // Write port registers only change when a word completes, so they
            // keep their last values outside WRITE.
            if (r_state == ST_DATA && w_last_byte) begin
                r_imem_addr  <= r_word_idx[ADDR_W-1:0];
                r_imem_wdata <= w_word;
            end

            if (r_state == ST_WRITE) begin
                r_word_idx <= w_idx_inc;
            end

            if (r_state == ST_HOLD) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end else begin
                r_hold_cnt <= 8'd0;
            end

`ifdef BOOT_CHECKSUM_EN
            if (w_next_state == ST_LEN && r_state != ST_LEN) begin
                r_sum <= 32'd0;
            end else if (r_state == ST_WRITE) begin
                r_sum <= r_sum + r_imem_wdata;
            end
`endif
        end
    end

    assign byte_ready  = r_byte_ready;
    assign imem_we     = r_imem_we;
    assign imem_addr   = r_imem_addr;
    assign imem_wdata  = r_imem_wdata;
    assign core_resetb = r_core_resetb;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_core_boot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_boot_sequencer
//  Purpose  : Self-checking bench for core_boot_sequencer. Images are built
//             as word lists; the expected memory writes (index, word) are
//             queued as each image is issued and a monitor pops and compares
//             them on every imem_we pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_boot_sequencer;

    localparam int IMEM_WORDS  = 1024;
    localparam int ADDR_W      = 10;
    localparam int HOLD_CYCLES = 4;
`ifdef BOOT_CHECKSUM_EN
    localparam int CSUM_BYTES  = 4;
`else
    localparam int CSUM_BYTES  = 0;
`endif

    logic              clk        = 1'b0;
    logic              resetb     = 1'b0;
    logic              boot_en    = 1'b0;
    logic              boot_req   = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data  = 8'd0;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_resetb;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_we_cyc = 0;
    int first_acc_cyc = 0;
    bit first_seen = 1'b0;
    int valid_mode = 0;      // 0 continuous, 1 toggling, 2 random
    bit toggle_ph = 1'b0;
    int rise_cyc = 0;

    logic [31:0] img[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] csum_bias = 32'd0;
`endif

    core_boot_sequencer #(
        .IMEM_WORDS (IMEM_WORDS),
        .ADDR_W     (ADDR_W),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .boot_en    (boot_en),
        .boot_req   (boot_req),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_resetb(core_resetb),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin : mon
        logic [31:0] ea;
        logic [31:0] ed;
        if (imem_we === 1'b1) begin
            last_we_cyc = cyc;
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%08h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                check("write_addr", 32'(imem_addr), ea);
                check("write_data", imem_wdata, ed);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_resetb"}, 32'(core_resetb), 32'd0);
        check({tag, "_byte_ready"},  32'(byte_ready),  32'd0);
        check({tag, "_imem_we"},     32'(imem_we),     32'd0);
        check({tag, "_imem_addr"},   32'(imem_addr),   32'd0);
        check({tag, "_imem_wdata"},  imem_wdata,       32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_done"},        32'(done),        32'd0);
        check({tag, "_err"},         32'(err),         32'd0);
    endtask

    task automatic apply_reset(input logic be);
        @(negedge clk);
        resetb     = 1'b0;
        boot_en    = be;
        boot_req   = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        resetb     = 1'b1;
        first_seen = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit sent = 1'b0;
        int waited = 0;
        while (!sent) begin
            @(negedge clk);
            case (valid_mode)
                0:       byte_valid = 1'b1;
                1: begin
                    toggle_ph  = ~toggle_ph;
                    byte_valid = toggle_ph;
                end
                default: byte_valid = 1'($urandom_range(0, 1));
            endcase
            byte_data = byte_valid ? b : 8'($urandom);
            if (byte_valid && byte_ready) begin
                @(posedge clk);
                #1;
                if (!first_seen) begin
                    first_seen    = 1'b1;
                    first_acc_cyc = cyc;
                end
                sent = 1'b1;
            end else if (++waited > 100) begin
                checks++;
                errors++;
                $display("FAIL byte_timeout: got byte_ready=%0b expected 1 within 100 cycles", byte_ready);
                sent = 1'b1;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic idle();
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Issue the image in img[]: length, words, optional checksum. The model of
    // the expected result is simply "word i of the list lands at address i".
    task automatic load_img();
        logic [31:0] sum = 32'd0;
        send_word(32'(img.size()));
        for (int i = 0; i < img.size(); i++) begin
            exp_addr_q.push_back(32'(i));
            exp_data_q.push_back(img[i]);
            sum += img[i];
            send_word(img[i]);
        end
`ifdef BOOT_CHECKSUM_EN
        send_word(sum + csum_bias);
`else
        sum = sum;
`endif
        idle();
    endtask

    task automatic wait_run();
        bit up = 1'b0;
        for (int i = 0; i < 400 && !up; i++) begin
            @(posedge clk);
            #1;
            if (core_resetb) begin
                up       = 1'b1;
                rise_cyc = cyc;
            end
        end
        if (!up) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: got core_resetb=0 expected 1 within 400 cycles");
        end
        check("run_done", 32'(done), 32'd1);
        check("run_err",  32'(err),  32'd0);
        check("run_busy", 32'(busy), 32'd0);
    endtask

    task automatic expect_error(input string tag);
        repeat (2) @(negedge clk);
        check({tag, "_err"},         32'(err),         32'd1);
        check({tag, "_byte_ready"},  32'(byte_ready),  32'd0);
        check({tag, "_core_resetb"}, 32'(core_resetb), 32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
    endtask

    initial begin
        int n;

        // Direct release: no writes, core out of reset 1+HOLD_CYCLES edges later.
        apply_reset(1'b0);
        n = 0;
        for (int i = 0; i < 50 && !core_resetb; i++) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bypass_release_cycles", 32'(n), 32'(1 + HOLD_CYCLES));
        check("bypass_done", 32'(done), 32'd1);

        // Two-word image, continuous bytes, with latency checks.
        apply_reset(1'b1);
        valid_mode = 0;
        img = '{32'h0000_0013, 32'h0000_006F};
        load_img();
        wait_run();
        check("full_load_latency", 32'(rise_cyc - first_acc_cyc),
              32'(4 + 5 * 2 + HOLD_CYCLES + CSUM_BYTES - 1));
        check("write_to_release", 32'(rise_cyc - last_we_cyc),
              32'(1 + CSUM_BYTES + HOLD_CYCLES));
        check("hold_addr", 32'(imem_addr), 32'd1);
        check("hold_wdata", imem_wdata, 32'h0000_006F);

        // Reload from RUN: core reset reasserts on the very next edge.
        @(negedge clk);
        boot_req = 1'b1;
        @(posedge clk);
        #1;
        check("reboot_core_resetb", 32'(core_resetb), 32'd0);
        check("reboot_busy", 32'(busy), 32'd1);
        @(negedge clk);
        boot_req = 1'b0;
        img = '{32'hDEAD_BEEF};
        load_img();
        wait_run();
        check("reboot_addr", 32'(imem_addr), 32'd0);
        check("reboot_wdata", imem_wdata, 32'hDEAD_BEEF);

        // Length exactly IMEM_WORDS is legal; then reset in the middle of DATA.
        @(negedge clk);
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
        send_word(32'(IMEM_WORDS));
        send_byte(8'hAA);
        send_byte(8'h55);
        check("maxlen_err", 32'(err), 32'd0);
        check("maxlen_ready", 32'(byte_ready), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        resetb     = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_data_reset");

        // Same two-word image with valid toggling every cycle.
        apply_reset(1'b1);
        valid_mode = 1;
        img = '{32'h0000_0013, 32'h0000_006F};
        load_img();
        wait_run();

        // Random images with random valid gaps.
        valid_mode = 2;
        for (int t = 0; t < 3; t++) begin
            apply_reset(1'b1);
            img.delete();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) img.push_back($urandom);
            load_img();
            wait_run();
        end

        // Illegal lengths: zero and IMEM_WORDS+1.
        valid_mode = 0;
        apply_reset(1'b1);
        send_word(32'd0);
        idle();
        expect_error("len_zero");
        @(negedge clk);
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
        repeat (5) @(negedge clk);
        check("error_ignores_boot_req", 32'(err), 32'd1);
        check("error_no_busy", 32'(busy), 32'd0);

        apply_reset(1'b1);
        send_word(32'(IMEM_WORDS + 1));
        idle();
        expect_error("len_over");

`ifdef BOOT_CHECKSUM_EN
        // 0x00000001 + 0xFFFFFFFF wraps to 0: matching checksum runs.
        apply_reset(1'b1);
        csum_bias = 32'd0;
        img = '{32'h0000_0001, 32'hFFFF_FFFF};
        load_img();
        wait_run();
        // Checksum 1 mismatches: words still written, then error.
        apply_reset(1'b1);
        csum_bias = 32'd1;
        load_img();
        expect_error("csum_bad");
        csum_bias = 32'd0;
`endif

        apply_reset(1'b0);
        repeat (8) @(negedge clk);
        check("pending_writes", 32'(exp_addr_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
